// File: rtl/octave_mode_ctrl.sv
// ---------------------------------------------------------------------------
// octave_mode_ctrl
//
// Purpose:
//   Turns single-cycle octave and mode button pulses into the current
//   octave index and waveform selection. Each accepted press starts a
//   lockout window. Any further presses during that window are ignored, so
//   one physical press produces one step.
//
// Configuration macro:
//   OCTAVE_BOUNCE_EN - when defined, the octave steps back and forth as
//                      0..OCT_MAX..0. When undefined, the octave wraps from
//                      OCT_MAX back to 0.
//
// Parameters:
//   OCT_MAX  - highest octave index (1..7)
//   LOCKOUT  - number of cycles that busy stays high after an accepted
//              press (>= 1)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   octave_pulse in   one-cycle octave button pulse (already synchronized)
//   mode_pulse   in   one-cycle mode button pulse (already synchronized)
//   octave       out  [2:0] current octave index, 0..OCT_MAX
//   mode         out  [1:0] waveform: 0 square, 1 saw, 2 triangle, 3 sine
//   busy         out  high while the lockout window is active
//   update       out  one-cycle strobe after octave and/or mode changed
// ---------------------------------------------------------------------------
module octave_mode_ctrl #(
    parameter int OCT_MAX = 4,
    parameter int LOCKOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       octave_pulse,
    input  logic       mode_pulse,
    output logic [2:0] octave,
    output logic [1:0] mode,
    output logic       busy,
    output logic       update
);

    localparam int            CW       = $clog2(LOCKOUT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOCKOUT - 1);
    localparam logic [2:0]    OCT_TOP  = 3'(OCT_MAX);

    typedef enum logic {
        S_READY,
        S_LOCKOUT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    octave_q, octave_d;
    logic [1:0]    mode_q, mode_d;
    logic          update_q, update_d;
    logic [2:0]    octave_step;

`ifdef OCTAVE_BOUNCE_EN
    logic dir_q, dir_d;
    logic dir_step;

    // dir_q is 1 while counting up. The direction flips on the step that
    // lands on either end, so the next press moves away from that end.
    always_comb begin
        octave_step = octave_q;
        dir_step    = dir_q;
        if (dir_q) begin
            octave_step = octave_q + 3'd1;
            if (octave_q + 3'd1 == OCT_TOP) begin
                dir_step = 1'b0;
            end
        end else begin
            octave_step = octave_q - 3'd1;
            if (octave_q == 3'd1) begin
                dir_step = 1'b1;
            end
        end
    end
`else
    always_comb begin
        octave_step = (octave_q == OCT_TOP) ? 3'd0 : octave_q + 3'd1;
    end
`endif

    // The counter holds LOCKOUT-1 on entry. The FSM leaves LOCKOUT on the
    // edge where the counter is already 0, so busy is high for exactly
    // LOCKOUT cycles and the counter never wraps below 0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        octave_d = octave_q;
        mode_d   = mode_q;
        update_d = 1'b0;
`ifdef OCTAVE_BOUNCE_EN
        dir_d    = dir_q;
`endif
        case (state_q)
            S_READY: begin
                if (octave_pulse || mode_pulse) begin
                    state_d  = S_LOCKOUT;
                    cnt_d    = CNT_LOAD;
                    update_d = 1'b1;
                    if (octave_pulse) begin
                        octave_d = octave_step;
`ifdef OCTAVE_BOUNCE_EN
                        dir_d    = dir_step;
`endif
                    end
                    if (mode_pulse) begin
                        mode_d = mode_q + 2'd1;
                    end
                end
            end
            S_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_READY;
            cnt_q    <= '0;
            octave_q <= 3'd0;
            mode_q   <= 2'd0;
            update_q <= 1'b0;
`ifdef OCTAVE_BOUNCE_EN
            dir_q    <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            octave_q <= octave_d;
            mode_q   <= mode_d;
            update_q <= update_d;
`ifdef OCTAVE_BOUNCE_EN
            dir_q    <= dir_d;
`endif
        end
    end

    assign octave = octave_q;
    assign mode   = mode_q;
    assign update = update_q;
    assign busy   = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_octave_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_octave_mode_ctrl
//
// Self-checking bench for octave_mode_ctrl with OCT_MAX=4 and LOCKOUT=4.
// A reference model is built from press counts and the time of the last
// accepted press. Its results are compared with the DUT outputs on every
// falling edge. Directed sequences also check hand-computed values.
// ---------------------------------------------------------------------------
module tb_octave_mode_ctrl;

    localparam int OCT_MAX = 4;
    localparam int LOCKOUT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       octave_pulse;
    logic       mode_pulse;
    logic [2:0] octave;
    logic [1:0] mode;
    logic       busy;
    logic       update;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    octave_mode_ctrl #(
        .OCT_MAX(OCT_MAX),
        .LOCKOUT(LOCKOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .octave_pulse(octave_pulse),
        .mode_pulse  (mode_pulse),
        .octave      (octave),
        .mode        (mode),
        .busy        (busy),
        .update      (update)
    );

    // Octave index after n accepted octave steps, counted from reset.
    function automatic int octaveFor(input int n);
        int p;
`ifdef OCTAVE_BOUNCE_EN
        p = n % (2 * OCT_MAX);
        return (p <= OCT_MAX) ? p : 2 * OCT_MAX - p;
`else
        p = n % (OCT_MAX + 1);
        return p;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model. A press is accepted when it arrives more than
    // LOCKOUT edges after the previous accepted press.
    int  edgeNum    = 0;
    bit  modelValid = 1'b0;
    bit  hasAccept  = 1'b0;
    int  lastAccept = 0;
    int  octSteps   = 0;
    int  modeSteps  = 0;
    int  expOct, expMode, expBusy, expUpdate;

    always @(posedge clk) begin
        edgeNum++;
        if (rst) begin
            modelValid = 1'b1;
            hasAccept  = 1'b0;
            octSteps   = 0;
            modeSteps  = 0;
        end else if ((octave_pulse || mode_pulse) &&
                     (!hasAccept || (edgeNum - lastAccept) > LOCKOUT)) begin
            hasAccept  = 1'b1;
            lastAccept = edgeNum;
            octSteps   = octSteps + int'(octave_pulse);
            modeSteps  = modeSteps + int'(mode_pulse);
        end
        expOct    = octaveFor(octSteps);
        expMode   = modeSteps % 4;
        expBusy   = (hasAccept && (edgeNum - lastAccept) < LOCKOUT) ? 1 : 0;
        expUpdate = (hasAccept && lastAccept == edgeNum) ? 1 : 0;
    end

    // Compare the DUT outputs with the model on every falling edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("model_octave", 32'(octave), expOct);
            checkOutput("model_mode",   32'(mode),   expMode);
            checkOutput("model_busy",   32'(busy),   expBusy);
            checkOutput("model_update", 32'(update), expUpdate);
        end
    end

    // Count update strobes as seen by the DUT.
    int updCount = 0;
    always @(negedge clk) begin
        if (update === 1'b1) updCount++;
    end

    // Drive one cycle of inputs. Inputs change on the falling edge, are
    // sampled on the rising edge, and the task returns on the next falling
    // edge.
    task automatic applyStimulus(input logic o, input logic m, input logic r);
        octave_pulse = o;
        mode_pulse   = m;
        rst          = r;
        @(negedge clk);
        octave_pulse = 1'b0;
        mode_pulse   = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int modeTab[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
`ifdef OCTAVE_BOUNCE_EN
    int octTab[10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
`else
    int octTab[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
`endif
    int busyCycles;

    initial begin
        octave_pulse = 1'b0;
        mode_pulse   = 1'b0;
        rst          = 1'b1;

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset_octave", 32'(octave), 0);
        checkOutput("reset_mode",   32'(mode),   0);
        checkOutput("reset_busy",   32'(busy),   0);
        checkOutput("reset_update", 32'(update), 0);

        // Press in the first cycle after reset, then measure the busy window
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("first_octave", 32'(octave), 1);
        checkOutput("first_update", 32'(update), 1);
        checkOutput("first_busy",   32'(busy),   1);
        idle(1);
        checkOutput("first_update_drop", 32'(update), 0);
        busyCycles = (busy === 1'b1) ? 2 : 1;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            idle(1);
            if (busy === 1'b1) busyCycles++;
        end
        checkOutput("busy_length", 32'(busyCycles), LOCKOUT);

        // Press timing: offset 0 accepted, 2 ignored, 4 ignored (the
        // return edge), 5 accepted
        updCount = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lockout_octave", 32'(octave), 3);
        idle(1);
        checkOutput("lockout_updates", 32'(updCount), 2);
        idle(LOCKOUT);

        // Mode wraps modulo 4
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("mode_seq", 32'(mode), modeTab[i]);
            idle(LOCKOUT);
        end

        // Octave stepping sequence
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("octave_seq", 32'(octave), octTab[i]);
            idle(LOCKOUT);
        end

        // Both pulses at once give one update and one lockout
        applyStimulus(1'b0, 1'b0, 1'b1);
        updCount = 0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("both_octave", 32'(octave), 1);
        checkOutput("both_mode",   32'(mode),   1);
        checkOutput("both_busy",   32'(busy),   1);
        idle(LOCKOUT);
        checkOutput("both_busy_end", 32'(busy),     0);
        checkOutput("both_updates",  32'(updCount), 1);
        idle(1);

        // Reset during lockout with a press on the same edge
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("abort_octave", 32'(octave), 0);
        checkOutput("abort_mode",   32'(mode),   0);
        checkOutput("abort_busy",   32'(busy),   0);
        checkOutput("abort_update", 32'(update), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("after_abort_octave", 32'(octave), 1);
        checkOutput("after_abort_update", 32'(update), 1);
        idle(LOCKOUT);

        // Random pulses with occasional resets, checked by the model only
        repeat (300) begin
            applyStimulus(1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 59) == 0));
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
